// File: rtl/fp_alu_seq.sv
// fp_alu_seq: sequential FP ALU (add.s/sub.s/mov.s/mtc1/compares) with valid/ready handshakes.
// States: IDLE accept | UNPACK classify+swap | ALIGN shift smaller | ADDSUB magnitude op | NORM lzc+shift | ROUND rne | DONE hold
module fp_alu_seq #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int CC_COUNT = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  fp_ctl,
  input  logic                        mov,
  input  logic [EXP_W+MAN_W:0]        din1,
  input  logic [EXP_W+MAN_W:0]        din2,
  input  logic [4:0]                  shamt,
  input  logic [4:0]                  rd,
  input  logic [$clog2(CC_COUNT)-1:0] cc_sel,
  input  logic [EXP_W+MAN_W:0]        general_input,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_wen,
  output logic [4:0]                  fp_write_addr,
  output logic [EXP_W+MAN_W:0]        fp_alures,
  output logic [CC_COUNT-1:0]         cc_flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;   // hidden bit, mantissa, guard, round, sticky
  localparam int XW  = EXP_W + 2;   // exponent with carry headroom and a sign bit
  localparam int LZW = $clog2(SW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] SH_MAX   = EXP_W'(MAN_W + 3);
  localparam logic [XW-1:0]    EMAX_X   = {2'b00, EXP_ONES};
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]        a_q, b_q, res_q, spec_val_q;
  logic                sub_q, sign_l_q, sign_s_q, spec_q, zero_q, wen_q;
  logic [EXP_W-1:0]    exp_l_q, diff_q;
  logic [MAN_W:0]      sig_l_q, sig_s_q;
  logic [SW-1:0]       al_q, norm_q;
  logic [SW:0]         sum_q;
  logic [XW-1:0]       exp_n_q;
  logic [4:0]          addr_q;
  logic [CC_COUNT-1:0] cc_q;

  function automatic logic [W-1:0] ord_key(input logic [W-1:0] x);
    return x[W-1] ? ~x : {1'b1, x[W-2:0]};
  endfunction

  function automatic logic is_nan(input logic [W-1:0] x);
    return (x[W-2:MAN_W] == EXP_ONES) && (x[MAN_W-1:0] != '0);
  endfunction

  logic cmp_nan, cmp_zero, cmp_eq, cmp_lt, cmp_gt, cmp_res, is_arith;
  always_comb begin
    cmp_nan  = is_nan(din1) || is_nan(din2);
    cmp_zero = (din1[W-2:0] == '0) && (din2[W-2:0] == '0);
    cmp_eq   = !cmp_nan && (cmp_zero || (din1 == din2));
    cmp_lt   = !cmp_nan && !cmp_zero && (ord_key(din1) < ord_key(din2));
    cmp_gt   = !cmp_nan && !cmp_zero && (ord_key(din1) > ord_key(din2));
    cmp_res  = 1'b0;
    case (fp_ctl)
      3'd2:    cmp_res = cmp_eq;
      3'd3:    cmp_res = cmp_lt;
      3'd4:    cmp_res = cmp_lt | cmp_eq;
      3'd5:    cmp_res = cmp_gt | cmp_eq;
      3'd6:    cmp_res = cmp_gt;
      default: cmp_res = 1'b0;
    endcase
    is_arith = ((fp_ctl == 3'd0) && !mov) || (fp_ctl == 3'd1);
  end

  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     ma, mb;
  logic [EXP_W+MAN_W-1:0] mag_a, mag_b;
  logic [MAN_W:0]       siga, sigb;
  logic                 sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap, spec_d;
  logic [W-1:0]         spec_val_d;
  always_comb begin
    ea     = a_q[W-2:MAN_W];
    ma     = a_q[MAN_W-1:0];
    sa     = a_q[W-1];
    eb     = b_q[W-2:MAN_W];
    mb     = b_q[MAN_W-1:0];
    sb     = b_q[W-1] ^ sub_q;
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_nan  = (ea == EXP_ONES) && (ma != '0);
    b_nan  = (eb == EXP_ONES) && (mb != '0);
    a_inf  = (ea == EXP_ONES) && (ma == '0);
    b_inf  = (eb == EXP_ONES) && (mb == '0);
    mag_a  = a_zero ? '0 : {ea, ma};
    mag_b  = b_zero ? '0 : {eb, mb};
    siga   = a_zero ? '0 : {1'b1, ma};
    sigb   = b_zero ? '0 : {1'b1, mb};
    swap   = mag_b > mag_a;
    spec_d     = 1'b1;
    spec_val_d = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) spec_val_d = QNAN;
    else if (a_inf) spec_val_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
    else if (b_inf) spec_val_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
    else spec_d = 1'b0;
  end

  logic [SW-1:0] ext_s, shifted, al_d;
  logic          lost;
  always_comb begin
    ext_s   = {sig_s_q, 3'b000};
    shifted = ext_s >> diff_q;
    lost    = |(ext_s & ~({SW{1'b1}} << diff_q));
    if (diff_q >= SH_MAX) al_d = {{(SW-1){1'b0}}, |sig_s_q};
    else al_d = {shifted[SW-1:1], shifted[0] | lost};
  end

  logic [SW:0] sum_d;
  always_comb begin
    if (sign_l_q ^ sign_s_q) sum_d = {1'b0, sig_l_q, 3'b000} - {1'b0, al_q};
    else sum_d = {1'b0, sig_l_q, 3'b000} + {1'b0, al_q};
  end

  logic [LZW-1:0] lz;
  logic           lz_found;
  logic [SW-1:0]  norm_d;
  logic [XW-1:0]  exp_n_d;
  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (sum_q[i]) lz_found = 1'b1;
      else if (!lz_found) lz = lz + LZW'(1);
    end
    if (sum_q[SW]) begin
      norm_d  = {sum_q[SW:2], sum_q[1] | sum_q[0]};
      exp_n_d = {2'b00, exp_l_q} + XW'(1);
    end else begin
      norm_d  = sum_q[SW-1:0] << lz;
      exp_n_d = {2'b00, exp_l_q} - XW'(lz);
    end
  end

  logic              rup;
  logic [MAN_W+1:0]  mant_r;
  logic [XW-1:0]     exp_r;
  logic [MAN_W-1:0]  frac_r;
  logic [W-1:0]      round_res;
  always_comb begin
    rup       = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    mant_r    = {1'b0, norm_q[SW-1:3]} + (MAN_W+2)'(rup);
    exp_r     = mant_r[MAN_W+1] ? exp_n_q + XW'(1) : exp_n_q;
    frac_r    = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    round_res = {sign_l_q, exp_r[EXP_W-1:0], frac_r};
    if (spec_q) round_res = spec_val_q;
    else if (zero_q || exp_r[XW-1] || (exp_r == '0)) round_res = '0;
    else if (exp_r >= EMAX_X) round_res = {sign_l_q, EXP_ONES, {MAN_W{1'b0}}};
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = is_arith ? S_UNPACK : S_DONE;
      end
      S_UNPACK: state_d = S_ALIGN;
      S_ALIGN:  state_d = S_ADDSUB;
      S_ADDSUB: state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; sub_q <= 1'b0;
      sign_l_q <= 1'b0; sign_s_q <= 1'b0; exp_l_q <= '0; diff_q <= '0;
      sig_l_q <= '0; sig_s_q <= '0; spec_q <= 1'b0; spec_val_q <= '0;
      al_q <= '0; sum_q <= '0; norm_q <= '0; exp_n_q <= '0; zero_q <= 1'b0;
      res_q <= '0; addr_q <= '0; wen_q <= 1'b0; cc_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          a_q   <= din1;
          b_q   <= din2;
          sub_q <= (fp_ctl == 3'd1);
          if (is_arith) begin
            addr_q <= shamt;
            wen_q  <= 1'b1;
          end else if (fp_ctl == 3'd0) begin
            res_q  <= din1;
            addr_q <= shamt;
            wen_q  <= 1'b1;
          end else if (fp_ctl == 3'd7) begin
            res_q  <= general_input;
            addr_q <= rd;
            wen_q  <= 1'b1;
          end else begin
            cc_q[cc_sel] <= cmp_res;
            res_q  <= '0;
            addr_q <= '0;
            wen_q  <= 1'b0;
          end
        end
        S_UNPACK: begin
          sign_l_q   <= swap ? sb : sa;
          sign_s_q   <= swap ? sa : sb;
          exp_l_q    <= swap ? eb : ea;
          sig_l_q    <= swap ? sigb : siga;
          sig_s_q    <= swap ? siga : sigb;
          diff_q     <= swap ? eb - ea : ea - eb;
          spec_q     <= spec_d;
          spec_val_q <= spec_val_d;
        end
        S_ALIGN:  al_q <= al_d;
        S_ADDSUB: sum_q <= sum_d;
        S_NORM: begin
          norm_q  <= norm_d;
          exp_n_q <= exp_n_d;
          zero_q  <= (sum_q == '0);
        end
        S_ROUND:  res_q <= round_res;
        default: ;
      endcase
    end
  end

  assign out_wen       = wen_q;
  assign fp_write_addr = addr_q;
  assign fp_alures     = res_q;
  assign cc_flags      = cc_q;

endmodule

// File: tb/tb_fp_alu_seq.sv
// Directed bench for fp_alu_seq: expected results are queued at issue and checked when out_valid rises.
`timescale 1ns/1ps
module tb_fp_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, mov, out_valid, out_ready, out_wen;
  logic [2:0]   fp_ctl, cc_sel;
  logic [W-1:0] din1, din2, general_input, fp_alures;
  logic [4:0]   shamt, rd, fp_write_addr;
  logic [7:0]   cc_flags;

  fp_alu_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fp_ctl(fp_ctl), .mov(mov), .din1(din1), .din2(din2), .shamt(shamt), .rd(rd),
    .cc_sel(cc_sel), .general_input(general_input), .out_valid(out_valid),
    .out_ready(out_ready), .out_wen(out_wen), .fp_write_addr(fp_write_addr),
    .fp_alures(fp_alures), .cc_flags(cc_flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [4:0]   addr;
    logic         wen;
    logic         chk_addr;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       dropped;
  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] cc_exp = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [2:0] ctl, input logic mv, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [4:0] fd, input logic [4:0] r,
                       input logic [2:0] sel, input logic [W-1:0] gi,
                       input logic [W-1:0] e_res, input logic [4:0] e_addr,
                       input logic e_wen, input logic e_chk_addr);
    chk("in_ready_before_issue", in_ready, 1);
    fp_ctl = ctl; mov = mv; din1 = d1; din2 = d2; shamt = fd; rd = r;
    cc_sel = sel; general_input = gi; in_valid = 1'b1;
    sb_q.push_back('{res: e_res, addr: e_addr, wen: e_wen, chk_addr: e_chk_addr});
    @(posedge clk); #1;
    in_valid = 1'b0;
    din1 = 'x; din2 = 'x; general_input = 'x;
  endtask

  task automatic wait_out(input string tag, input int lat_exp);
    int   lat;
    exp_t e;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      chk({tag, "_busy_in_ready"}, in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, lat_exp);
    if (sb_q.size() != 0) e = sb_q.pop_front();
    else e = '1;
    chk({tag, "_res"}, fp_alures, e.res);
    chk({tag, "_wen"}, out_wen, e.wen);
    if (e.chk_addr) chk({tag, "_addr"}, fp_write_addr, e.addr);
    chk({tag, "_cc"}, cc_flags, cc_exp);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_in_ready_after"}, in_ready, 1);
      chk({tag, "_out_valid_after"}, out_valid, 0);
    end
  endtask

  task automatic arith(input string tag, input logic is_sub, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] fd, input logic [W-1:0] e_res);
    issue(is_sub ? 3'd1 : 3'd0, 1'b0, a, b, fd, 5'd0, 3'd0, '0, e_res, fd, 1'b1, 1'b1);
    wait_out(tag, 6);
  endtask

  task automatic cmpop(input string tag, input logic [2:0] ctl, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2:0] sel, input logic e_bit);
    issue(ctl, 1'b0, a, b, 5'd0, 5'd0, sel, '0, '0, 5'd0, 1'b0, 1'b0);
    cc_exp[sel] = e_bit;
    wait_out(tag, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mov = 1'b0; fp_ctl = '0;
    din1 = '0; din2 = '0; shamt = '0; rd = '0; cc_sel = '0; general_input = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_wen", out_wen, 0);
    chk("rst_addr", fp_write_addr, 0);
    chk("rst_res", fp_alures, 0);
    chk("rst_cc", cc_flags, 0);

    arith("add_1p2", 1'b0, 32'h3F800000, 32'h40000000, 5'd5, 32'h40400000);
    arith("sub_1m1", 1'b1, 32'h3F800000, 32'h3F800000, 5'd6, 32'h00000000);
    arith("add_tie_even", 1'b0, 32'h3F800000, 32'h33800000, 5'd7, 32'h3F800000);
    arith("add_round_up", 1'b0, 32'h3F800000, 32'h33C00000, 5'd8, 32'h3F800001);
    arith("add_overflow", 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'd1, 32'h7F800000);
    arith("sub_inf_inf", 1'b1, 32'h7F800000, 32'h7F800000, 5'd2, 32'h7FC00000);
    arith("add_denorm", 1'b0, 32'h00000001, 32'h00000000, 5'd3, 32'h00000000);
    arith("sub_3m1", 1'b1, 32'h40400000, 32'h3F800000, 5'd4, 32'h40000000);
    arith("add_m2p1", 1'b0, 32'hC0000000, 32'h3F800000, 5'd10, 32'hBF800000);

    cmpop("lt_1_2", 3'd3, 32'h3F800000, 32'h40000000, 3'd3, 1'b1);
    chk("lt_cc_value", cc_flags, 8'h08);
    cmpop("eq_negz_posz", 3'd2, 32'h80000000, 32'h00000000, 3'd0, 1'b1);
    cmpop("eq_nan_nan", 3'd2, 32'h7FC00000, 32'h7FC00000, 3'd0, 1'b0);
    cmpop("gt_2_m3", 3'd6, 32'h40000000, 32'hC0400000, 3'd7, 1'b1);

    issue(3'd0, 1'b1, 32'hC0490FDB, 32'h3F800000, 5'd12, 5'd0, 3'd0, '0,
          32'hC0490FDB, 5'd12, 1'b1, 1'b1);
    wait_out("mov", 1);

    out_ready = 1'b0;
    arith("bp_add", 1'b0, 32'h3F800000, 32'h40000000, 5'd13, 32'h40400000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_res", fp_alures, 32'h40400000);
      chk("bp_addr", fp_write_addr, 5'd13);
      chk("bp_wen", out_wen, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);

    issue(3'd7, 1'b0, '0, '0, 5'd0, 5'd9, 3'd0, 32'h12345678, 32'h12345678, 5'd9, 1'b1, 1'b1);
    wait_out("mtc1", 1);

    issue(3'd0, 1'b0, 32'h3F800000, 32'h40000000, 5'd14, 5'd0, 3'd0, '0,
          32'h40400000, 5'd14, 1'b1, 1'b1);
    chk("abort_unpack_busy", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dropped = sb_q.pop_back();
    cc_exp = '0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_wen", out_wen, 0);
    chk("abort_addr", fp_write_addr, 0);
    chk("abort_res", fp_alures, 0);
    chk("abort_cc", cc_flags, 0);
    arith("add_after_abort", 1'b0, 32'h40000000, 32'h40000000, 5'd15, 32'h40800000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
